// File: rtl/fpga_clk_ctrl_pkg.sv
// Shared types and widths for the FPGA core run-control block.
package fpga_clk_ctrl_pkg;

   localparam int unsigned CYCLE_CNT_W = 64;
   localparam int unsigned STEP_W      = 32;

   typedef enum logic [1:0] {
      OP_PAUSE = 2'd0,
      OP_RUN   = 2'd1,
      OP_STEP  = 2'd2,
      OP_CLEAR = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_PAUSED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } state_t;

endpackage

// File: rtl/fpga_clk_resume_timer.sv
// Resume holdoff after stall release: keeps ready low for RESUME_DELAY
// cycles after stall is first seen low. ready reflects the count that will
// hold after this edge so the registered enable lands exactly on time.
module fpga_clk_resume_timer #(
   parameter int unsigned RESUME_DELAY = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic stall,
   output logic ready
);

   localparam int unsigned CNT_W = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY + 1) : 1;

   logic             stall_q;
   logic [CNT_W-1:0] resume_cnt;
   logic [CNT_W-1:0] resume_cnt_n;

   // Next count: cleared while stalled, reloaded on the falling edge, then counts down.
   always_comb begin
      resume_cnt_n = resume_cnt;
      if (stall) begin
         resume_cnt_n = '0;
      end else if (stall_q) begin
         resume_cnt_n = CNT_W'(RESUME_DELAY);
      end else if (resume_cnt != '0) begin
         resume_cnt_n = resume_cnt - CNT_W'(1);
      end
   end

   assign ready = (resume_cnt_n == '0);

   // Stall history and countdown register.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q    <= 1'b0;
         resume_cnt <= '0;
      end else begin
         stall_q    <= stall;
         resume_cnt <= resume_cnt_n;
      end
   end

endmodule

// File: rtl/fpga_clock_ctrl.sv
// Run-control stage producing core_clock_enable for the core clock gate.
// Optional stall watchdog enabled by defining FPGA_CLK_CTRL_TIMEOUT_EN.
module fpga_clock_ctrl
   import fpga_clk_ctrl_pkg::*;
#(
   parameter int unsigned RESUME_DELAY   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [STEP_W-1:0]      cmd_arg,
   input  logic                   stall,
   output logic                   core_clock_enable,
   output logic                   step_done,
   output logic                   running,
   output logic [CYCLE_CNT_W-1:0] cycle_count,
   output logic                   timeout
);

   state_t                 state, state_n;
   logic [STEP_W-1:0]      remaining, remaining_n;
   logic [CYCLE_CNT_W-1:0] count_n;
   logic                   enable_n;
   logic                   done_n;
   logic                   ready;

   fpga_clk_resume_timer #(
      .RESUME_DELAY (RESUME_DELAY)
   ) u_resume_timer (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .ready (ready)
   );

   assign cmd_ready = 1'b1;
   assign running   = (state != ST_PAUSED);

   // Next state: step bookkeeping from the current enabled cycle, then any
   // accepted command overrides it (CLEAR only touches the counter).
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      count_n     = cycle_count;
      done_n      = 1'b0;
      if (core_clock_enable) begin
         count_n = cycle_count + CYCLE_CNT_W'(1);
         if (state == ST_STEPPING) begin
            if (remaining == STEP_W'(1)) begin
               state_n     = ST_PAUSED;
               remaining_n = '0;
               done_n      = 1'b1;
            end else begin
               remaining_n = remaining - STEP_W'(1);
            end
         end
      end
      if (cmd_valid) begin
         case (op_t'(cmd_op))
            OP_PAUSE: begin
               state_n     = ST_PAUSED;
               remaining_n = '0;
               done_n      = 1'b0;
            end
            OP_RUN: begin
               state_n     = ST_RUNNING;
               remaining_n = '0;
               done_n      = 1'b0;
            end
            OP_STEP: begin
               if (cmd_arg != '0) begin
                  state_n     = ST_STEPPING;
                  remaining_n = cmd_arg;
                  done_n      = 1'b0;
               end else begin
                  done_n = 1'b1;
               end
            end
            OP_CLEAR: count_n = '0;
            default: ;
         endcase
      end
      enable_n = (state_n != ST_PAUSED) & ~stall & ready;
   end

   // Control state and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= ST_PAUSED;
         remaining         <= '0;
         cycle_count       <= '0;
         core_clock_enable <= 1'b0;
         step_done         <= 1'b0;
      end else begin
         state             <= state_n;
         remaining         <= remaining_n;
         cycle_count       <= count_n;
         core_clock_enable <= enable_n;
         step_done         <= done_n;
      end
   end

`ifdef FPGA_CLK_CTRL_TIMEOUT_EN
   logic [31:0] stall_run;
   logic        clear_cmd;

   assign clear_cmd = cmd_valid & (op_t'(cmd_op) == OP_CLEAR);

   // Watchdog: consecutive stalled cycles while not paused; saturates at the limit.
   always_ff @(posedge clock) begin
      if (reset || clear_cmd) begin
         stall_run <= '0;
         timeout   <= 1'b0;
      end else if (stall && (state != ST_PAUSED)) begin
         if (stall_run != 32'(TIMEOUT_CYCLES)) begin
            stall_run <= stall_run + 32'd1;
         end
         if (stall_run + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
            timeout <= 1'b1;
         end
      end else begin
         stall_run <= '0;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_clock_ctrl.sv
// Self-checking bench for fpga_clock_ctrl: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural model.
module tb_fpga_clock_ctrl;

   localparam int unsigned RD = 2;
   localparam int unsigned TO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        stall;
   logic        core_clock_enable;
   logic        step_done;
   logic        running;
   logic [63:0] cycle_count;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 paused, 1 running, 2 stepping.
   int              m_state;
   int unsigned     m_rem;
   longint unsigned m_count;
   bit              m_en;
   bit              m_done;
   int              m_low_run;
   int unsigned     m_tcnt;
   bit              m_tout;

   fpga_clock_ctrl #(
      .RESUME_DELAY   (RD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_op            (cmd_op),
      .cmd_arg           (cmd_arg),
      .stall             (stall),
      .core_clock_enable (core_clock_enable),
      .step_done         (step_done),
      .running           (running),
      .cycle_count       (cycle_count),
      .timeout           (timeout)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge(input bit r, input bit v, input bit [1:0] op,
                             input bit [31:0] arg, input bit st);
      int          ns;
      int unsigned nrem;
      if (r) begin
         m_state = 0; m_rem = 0; m_count = 0; m_en = 0; m_done = 0;
         m_low_run = 1000; m_tcnt = 0; m_tout = 0;
         return;
      end
      // watchdog looks at the state during this cycle
      if (v && op == 2'd3) begin
         m_tcnt = 0; m_tout = 0;
      end else if (st && m_state != 0) begin
         if (m_tcnt < TO) m_tcnt++;
         if (m_tcnt >= TO) m_tout = 1;
      end else begin
         m_tcnt = 0;
      end
      ns = m_state; nrem = m_rem; m_done = 0;
      if (m_en) begin
         m_count++;
         if (m_state == 2) begin
            if (m_rem == 1) begin ns = 0; nrem = 0; m_done = 1; end
            else nrem = m_rem - 1;
         end
      end
      if (v) begin
         case (op)
            2'd0: begin ns = 0; nrem = 0; m_done = 0; end
            2'd1: begin ns = 1; nrem = 0; m_done = 0; end
            2'd2: if (arg != 0) begin ns = 2; nrem = arg; m_done = 0; end
                  else m_done = 1;
            default: m_count = 0;
         endcase
      end
      m_state = ns; m_rem = nrem;
      // enable returns once stall has been low for RD+1 sampled cycles
      if (st) m_low_run = 0;
      else if (m_low_run < 1000) m_low_run++;
      m_en = (m_state != 0) && !st && (m_low_run >= int'(RD) + 1);
   endtask

   task automatic tick(input bit r, input bit v, input bit [1:0] op,
                       input bit [31:0] arg, input bit st);
      reset = r; cmd_valid = v; cmd_op = op; cmd_arg = arg; stall = st;
      @(posedge clock);
      model_edge(r, v, op, arg, st);
      @(negedge clock);
      check_eq("enable",      64'(core_clock_enable), 64'(m_en));
      check_eq("step_done",   64'(step_done),         64'(m_done));
      check_eq("running",     64'(running),           64'(m_state != 0));
      check_eq("cycle_count", cycle_count,            m_count);
      check_eq("cmd_ready",   64'(cmd_ready),         64'd1);
`ifdef FPGA_CLK_CTRL_TIMEOUT_EN
      check_eq("timeout",     64'(timeout),           64'(m_tout));
`else
      check_eq("timeout",     64'(timeout),           64'd0);
`endif
   endtask

   task automatic idle(input bit st);
      tick(1'b0, 1'b0, 2'd0, 32'd0, st);
   endtask

   int en_seen, done_seen;
   bit st_r;
   int stall_hold;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; stall = 1'b0;

      // reset state
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      check_eq("reset_count",  cycle_count, 64'd0);
      check_eq("reset_enable", 64'(core_clock_enable), 64'd0);
      check_eq("reset_ready",  64'(cmd_ready), 64'd1);
      idle(1'b0);

      // STEP 5
      en_seen = 0; done_seen = 0;
      tick(1'b0, 1'b1, 2'd2, 32'd5, 1'b0);
      en_seen += int'(core_clock_enable); done_seen += int'(step_done);
      for (int i = 0; i < 7; i++) begin
         idle(1'b0);
         en_seen += int'(core_clock_enable); done_seen += int'(step_done);
      end
      check_eq("step5_en_cycles", 64'(en_seen), 64'd5);
      check_eq("step5_done",      64'(done_seen), 64'd1);
      check_eq("step5_count",     cycle_count, 64'd5);
      check_eq("step5_paused",    64'(running), 64'd0);

      // RUN with a 10-cycle stall
      tick(1'b0, 1'b1, 2'd1, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      idle(1'b1);
      check_eq("stall_drop", 64'(core_clock_enable), 64'd0);
      for (int i = 0; i < 9; i++) idle(1'b1);
      idle(1'b0); check_eq("resume_1", 64'(core_clock_enable), 64'd0);
      idle(1'b0); check_eq("resume_2", 64'(core_clock_enable), 64'd0);
      idle(1'b0); check_eq("resume_3", 64'(core_clock_enable), 64'd1);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // CLEAR coinciding with an enabled cycle
      tick(1'b0, 1'b1, 2'd3, 32'd0, 1'b0);
      check_eq("clear_zero", cycle_count, 64'd0);
      idle(1'b0); check_eq("clear_plus1", cycle_count, 64'd1);
      idle(1'b0); check_eq("clear_plus2", cycle_count, 64'd2);

      // STEP 100 aborted by PAUSE after 40 enabled cycles
      tick(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
      tick(1'b0, 1'b1, 2'd3, 32'd0, 1'b0);
      done_seen = 0;
      tick(1'b0, 1'b1, 2'd2, 32'd100, 1'b0);
      for (int i = 0; i < 39; i++) begin
         idle(1'b0); done_seen += int'(step_done);
      end
      tick(1'b0, 1'b1, 2'd0, 32'd0, 1'b0); done_seen += int'(step_done);
      idle(1'b0); done_seen += int'(step_done);
      check_eq("abort_no_done", 64'(done_seen), 64'd0);
      check_eq("abort_count",   cycle_count, 64'd40);
      check_eq("abort_enable",  64'(core_clock_enable), 64'd0);

      // STEP 0
      tick(1'b0, 1'b1, 2'd2, 32'd0, 1'b0);
      check_eq("step0_done",   64'(step_done), 64'd1);
      check_eq("step0_enable", 64'(core_clock_enable), 64'd0);
      idle(1'b0);
      check_eq("step0_count",  cycle_count, 64'd40);

      // Stall watchdog
      tick(1'b0, 1'b1, 2'd1, 32'd0, 1'b0);
      for (int i = 0; i < 16; i++) idle(1'b1);
      for (int i = 0; i < 5; i++) idle(1'b0);
`ifdef FPGA_CLK_CTRL_TIMEOUT_EN
      check_eq("timeout_sticky", 64'(timeout), 64'd1);
`else
      check_eq("timeout_off", 64'(timeout), 64'd0);
`endif
      tick(1'b0, 1'b1, 2'd3, 32'd0, 1'b0);
      check_eq("timeout_clear", 64'(timeout), 64'd0);

      // Random traffic
      st_r = 1'b0; stall_hold = 0;
      for (int i = 0; i < 800; i++) begin
         int unsigned dice;
         dice = $urandom_range(0, 99);
         if (stall_hold == 0) begin
            st_r = ($urandom_range(0, 3) == 0);
            stall_hold = int'($urandom_range(1, st_r ? 20 : 10));
         end
         stall_hold--;
         if (dice < 2)
            tick(1'b1, 1'b0, 2'd0, 32'd0, st_r);
         else if (dice < 30)
            tick(1'b0, 1'b1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 12)), st_r);
         else
            idle(st_r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
